// File: rtl/mult8_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
//   MULT_W  - operand width of the shared multiplier
//   PROD_W  - full product width, never truncated
//   fsm_state_t - scheduler control states
package mult8_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 2 * MULT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/mult8_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above ptr, wrapping.
//   req     - request vector
//   ptr     - highest-priority index for this decision
//   en      - grant opportunity; gnt stays zero when low
//   gnt     - one-hot grant (zero when disabled or nothing requested)
//   gnt_idx - binary index of the winner (valid whenever |req)
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   k;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_8bits_version15.sv
// Combinational 8x8 unsigned multiplier. Partial products are accumulated
// through a 16-bit Kogge-Stone parallel-prefix adder.
//   A, B - unsigned operands
//   P    - full 16-bit product
module multiplier_8bits_version15 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    // Prefix tree: after log2(16) levels g[i] is the carry out of bit i,
    // so the carry into bit i+1 is g[i] and the sum is p ^ (g << 1).
    function automatic logic [15:0] ks_add16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] h;
        g = x & y;
        p = x ^ y;
        h = p;
        for (int d = 1; d < 16; d = d * 2) begin
            g = g | (p & (g << d));
            p = p & (p << d);
        end
        return h ^ {g[14:0], 1'b0};
    endfunction

    always_comb begin
        logic [15:0] acc;
        logic [15:0] pp;
        acc = 16'd0;
        pp  = 16'd0;
        for (int i = 0; i < 8; i++) begin
            pp  = B[i] ? ({8'd0, A} << i) : 16'd0;
            acc = ks_add16(acc, pp);
        end
        P = acc;
    end

endmodule

// File: rtl/mult8_rr_scheduler.sv
// Shares one combinational 8x8 multiplier between NREQ requesters.
// Requesters are granted round-robin; operands and product are registered,
// and each product is returned with its requester ID on a valid/ready channel.
//   clk, rst     - clock, synchronous active-high reset
//   req_valid/req_a/req_b/req_ready - per-requester operand channels
//   rsp_valid/rsp_ready/rsp_product/rsp_id - result channel
//   busy         - high in MUL and RESP
//
// state | meaning
// IDLE  | nothing in flight; grant any valid requester
// MUL   | operands registered; multiplier output captured at end of cycle
// RESP  | product presented; on handshake grant the next requester or idle
import mult8_pkg::*;

module mult8_rr_scheduler #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [MULT_W*NREQ-1:0] req_a,
    input  logic [MULT_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PROD_W-1:0]      rsp_product,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    fsm_state_t        state;
    fsm_state_t        state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [MULT_W-1:0] op_a;
    logic [MULT_W-1:0] op_b;
    logic [ID_W-1:0]   op_id;
    logic              grant_en;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              grant;
    logic [PROD_W-1:0] mult_p;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    multiplier_8bits_version15 u_mult (
        .A (op_a),
        .B (op_b),
        .P (mult_p)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? MUL : IDLE;
            MUL:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = grant ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants and busy are masked during reset so nothing leaks out while
    // the state register still holds its pre-reset value.
    always_comb begin
        grant_en = 1'b0;
        busy     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: grant_en = 1'b1;
                MUL:  busy     = 1'b1;
                RESP: begin
                    busy     = 1'b1;
                    grant_en = rsp_ready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
        end else begin
            if (grant) begin
                op_a   <= req_a[gnt_idx*MULT_W +: MULT_W];
                op_b   <= req_b[gnt_idx*MULT_W +: MULT_W];
                op_id  <= gnt_idx;
                rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
            if (state == MUL) begin
                rsp_product <= mult_p;
                rsp_id      <= op_id;
                rsp_valid   <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult8_rr_scheduler.sv
module tb_mult8_rr_scheduler;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  v;
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_product;
    logic [1:0]  rsp_id;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one transaction at most in flight.
    int       cyc      = 0;
    bit       have_txn = 0;
    int       grant_c  = 0;
    int       m_ptr    = 0;
    int       exp_id   = 0;
    int       exp_a    = 0;
    int       exp_b    = 0;
    bit       just_rst = 0;
    logic [3:0] fire_mask = '0;

    always #5 clk = ~clk;

    mult8_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (v),
        .req_a       ({a[3], a[2], a[1], a[0]}),
        .req_b       ({b[3], b[2], b[1], b[0]}),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit       exp_rv;
        bit       exp_busy;
        bit       opp;
        int       win;
        int       idx;
        logic [3:0] exp_rdy;
        cyc++;
        if (rst) begin
            check_val("rst_req_ready", 32'(req_ready), 32'd0);
            check_val("rst_busy", 32'(busy), 32'd0);
            have_txn  = 0;
            m_ptr     = 0;
            just_rst  = 1;
            fire_mask = '0;
        end else begin
            exp_rv   = have_txn && (cyc - grant_c >= 2);
            exp_busy = have_txn && (cyc - grant_c >= 1);
            check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check_val("busy", 32'(busy), 32'(exp_busy));
            if (just_rst) begin
                check_val("post_rst_product", 32'(rsp_product), 32'd0);
                check_val("post_rst_id", 32'(rsp_id), 32'd0);
                just_rst = 0;
            end
            if (exp_rv) begin
                check_val("rsp_product", 32'(rsp_product), 32'(exp_a * exp_b));
                check_val("rsp_id", 32'(rsp_id), 32'(exp_id));
            end
            opp = !have_txn || (exp_rv && rsp_ready);
            win = -1;
            if (opp) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (win < 0 && v[idx]) win = idx;
                end
            end
            exp_rdy = (win >= 0) ? 4'(1 << win) : 4'd0;
            check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_rv && rsp_ready) have_txn = 0;
            if (win >= 0) begin
                have_txn = 1;
                grant_c  = cyc;
                exp_id   = win;
                exp_a    = int'(a[win]);
                exp_b    = int'(b[win]);
                m_ptr    = (win + 1) % NREQ;
            end
            fire_mask = exp_rdy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and drop it once taken; bounded wait.
    task automatic send(input int id, input logic [7:0] va, input logic [7:0] vb);
        bit done;
        done  = 0;
        v[id] = 1'b1;
        a[id] = va;
        b[id] = vb;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (fire_mask[id]) done = 1;
        end
        v[id] = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL send_timeout: requester %0d never granted", id);
        end
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       rand_op = 8'h00;
            1:       rand_op = 8'hFF;
            2:       rand_op = 8'h80;
            default: rand_op = 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic run_random(input int cycles, input int vprob, input int rdyprob);
        for (int n = 0; n < cycles; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (fire_mask[i]) v[i] = 1'b0;
                if (!v[i] && $urandom_range(1, 100) <= vprob) begin
                    v[i] = 1'b1;
                    a[i] = rand_op();
                    b[i] = rand_op();
                end
            end
            rsp_ready = ($urandom_range(1, 100) <= rdyprob);
        end
        v = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) step();
    endtask

    initial begin
        logic [7:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        rst       = 1'b1;
        v         = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // single request, max operands
        send(2, 8'hFF, 8'hFF);
        repeat (4) step();

        // all requesters continuously valid
        run_random(12, 100, 100);

        // backpressure: response held while another requester waits
        rsp_ready = 1'b0;
        send(1, 8'h21, 8'h43);
        v[3] = 1'b1;
        a[3] = 8'h0F;
        b[3] = 8'hF0;
        repeat (7) step();
        rsp_ready = 1'b1;
        send(3, 8'h0F, 8'hF0);
        repeat (4) step();

        // reset while the product is being formed
        v[0] = 1'b1;
        a[0] = 8'h12;
        b[0] = 8'h34;
        for (int n = 0; n < 10 && !fire_mask[0]; n++) step();
        v[0] = 1'b0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        run_random(10, 100, 100);

        // edge operands
        send(0, 8'h00, 8'hFF);
        send(1, 8'h01, 8'h80);
        send(2, 8'h80, 8'h80);
        repeat (4) step();

        // corner cross product on rotating requesters
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                send((i * 6 + j) % NREQ, corners[i], corners[j]);
        repeat (4) step();

        // randomized traffic with response stalls
        run_random(8000, 40, 70);
        run_random(4000, 90, 95);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
